// File: rtl/video_pixel_fetch.sv
// video_pixel_fetch
//   Pixel fetch and colour expansion between the VGA timing generator and the
//   shared frame RAM. Each screen coordinate is mapped into a positioned,
//   integer-scaled source image. Packed 8-bit pixels are fetched from
//   word-wide RAM, with one read per new word. Each byte is expanded to
//   24-bit RGB (GRAY8 or RGB332). Latency from x/y sample to r/g/b is
//   MEM_LAT+2 cycles.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   x, y         current screen column / row
//   active       visible-area flag
//   mode         0 = GRAY8, 1 = RGB332 (sampled per pixel)
//   mem_addr     RAM word address (registered)
//   mem_rd_en    RAM read strobe (registered)
//   mem_rdata    RAM read data, valid MEM_LAT cycles after mem_addr/mem_rd_en
//   r, g, b      colour outputs to the DAC
//   pix_valid    r/g/b carry an in-image pixel
//   frame_done   one-cycle pulse on the last image pixel
//   frame_cnt    completed-frame counter (wraps)
module video_pixel_fetch #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 16,
  parameter int          COORD_W     = 10,
  parameter int          IMG_W       = 392,
  parameter int          IMG_H       = 392,
  parameter int          X0          = 0,
  parameter int          Y0          = 0,
  parameter int          SCALE_SHIFT = 0,
  parameter int          MEM_LAT     = 1,
  parameter int          BASE_ADDR   = 0,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               active,
  input  logic               mode,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               pix_valid,
  output logic               frame_done,
  output logic [15:0]        frame_cnt
);

  localparam int PPW    = DATA_W / 8;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int P      = MEM_LAT + 1;            // pipeline depth to the data stage
  localparam int W_SC   = IMG_W << SCALE_SHIFT;
  localparam int H_SC   = IMG_H << SCALE_SHIFT;

  // ---------------------------------------------------------------------------
  // Stage 0: coordinate mapping
  // ---------------------------------------------------------------------------
  logic signed [COORD_W:0] rx_s, ry_s;
  logic [31:0]             rx_w, ry_w, sx, sy, idx;
  logic                    x_in, y_in, in_img, last_pix;
  logic [ADDR_W-1:0]       waddr;
  logic [LANE_W-1:0]       lane;
  logic                    rd_d;

  logic [ADDR_W-1:0]       mem_addr_q;
  logic                    mem_rd_en_q;
  logic                    last_ok_q;

  assign rx_s = $signed({1'b0, x}) - $signed((COORD_W+1)'(X0));
  assign ry_s = $signed({1'b0, y}) - $signed((COORD_W+1)'(Y0));

  // Magnitudes are only meaningful when the sign bit is clear; x_in/y_in gate that.
  assign rx_w = {{(32-COORD_W){1'b0}}, rx_s[COORD_W-1:0]};
  assign ry_w = {{(32-COORD_W){1'b0}}, ry_s[COORD_W-1:0]};

  assign x_in   = !rx_s[COORD_W] && (rx_w < 32'(W_SC));
  assign y_in   = !ry_s[COORD_W] && (ry_w < 32'(H_SC));
  assign in_img = active && x_in && y_in;

  assign sx  = rx_w >> SCALE_SHIFT;
  assign sy  = ry_w >> SCALE_SHIFT;
  assign idx = sy * 32'(IMG_W) + sx;

  assign waddr = ADDR_W'(32'(BASE_ADDR) + idx / 32'(PPW));
  assign lane  = LANE_W'(idx % 32'(PPW));

  assign last_pix = in_img && (rx_w == 32'(W_SC - 1)) && (ry_w == 32'(H_SC - 1));

  // mem_addr only changes on an issued read, so it doubles as the last-issued address.
  assign rd_d = in_img && (!last_ok_q || (waddr != mem_addr_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      last_ok_q   <= 1'b0;
    end else begin
      mem_rd_en_q <= rd_d;
      if (rd_d) begin
        mem_addr_q <= waddr;
      end
      if (!in_img) begin
        last_ok_q <= 1'b0;
      end else if (rd_d) begin
        last_ok_q <= 1'b1;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;

  // ---------------------------------------------------------------------------
  // Alignment pipeline: MEM_LAT+1 stages so the last stage meets mem_rdata
  // ---------------------------------------------------------------------------
  logic [P-1:0]             img_pq, act_pq, mode_pq, iss_pq, last_pq;
  logic [P-1:0][LANE_W-1:0] lane_pq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_pq  <= '0;
      act_pq  <= '0;
      mode_pq <= '0;
      iss_pq  <= '0;
      last_pq <= '0;
      lane_pq <= '0;
    end else begin
      img_pq  <= {img_pq[P-2:0],  in_img};
      act_pq  <= {act_pq[P-2:0],  active};
      mode_pq <= {mode_pq[P-2:0], mode};
      iss_pq  <= {iss_pq[P-2:0],  rd_d};
      last_pq <= {last_pq[P-2:0], last_pix};
      lane_pq <= {lane_pq[P-2:0], lane};
    end
  end

  // ---------------------------------------------------------------------------
  // Data stage: word select, byte select, colour expansion
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] word;
  logic [7:0]        pix;
  logic [7:0]        exp_r, exp_g, exp_b;

  // Reads return in order, so the hold register always has the most recent issued word.
  assign word = iss_pq[P-1] ? mem_rdata : hold_q;
  assign pix  = word[{lane_pq[P-1], 3'b000} +: 8];

  always_comb begin
    exp_r = pix;
    exp_g = pix;
    exp_b = pix;
    if (mode_pq[P-1]) begin
      exp_r = {pix[7:5], pix[7:5], pix[7:6]};
      exp_g = {pix[4:2], pix[4:2], pix[4:3]};
      exp_b = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (iss_pq[P-1]) begin
      hold_q <= mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [7:0]  r_q, g_q, b_q;
  logic        pix_valid_q, frame_done_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      if (img_pq[P-1]) begin
        r_q         <= exp_r;
        g_q         <= exp_g;
        b_q         <= exp_b;
        pix_valid_q <= 1'b1;
      end else if (act_pq[P-1]) begin
        r_q         <= BORDER_RGB[23:16];
        g_q         <= BORDER_RGB[15:8];
        b_q         <= BORDER_RGB[7:0];
        pix_valid_q <= 1'b0;
      end else begin
        r_q         <= '0;
        g_q         <= '0;
        b_q         <= '0;
        pix_valid_q <= 1'b0;
      end
      frame_done_q <= last_pq[P-1];
      if (last_pq[P-1]) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/video_pixel_fetch.md
Name: video_pixel_fetch

Overview:
Parametrised pixel fetch and colour expansion stage between the VGA timing generator and the shared frame RAM. It takes the current screen coordinate and fetches packed 8-bit pixels from word-wide memory through a latency-aligned pipeline. Only one read is issued per new word. The image can be positioned and integer-scaled, and each byte is expanded to 24-bit RGB in GRAY8 or RGB332 mode. Outputs go straight to the DAC/video pins.

Parameters:
DATA_W, 32, RAM word width; must be a multiple of 8; PPW = DATA_W/8 pixels per word
ADDR_W, 16, RAM word-address width
COORD_W, 10, screen coordinate width
IMG_W, 392, source image width in pixels
IMG_H, 392, source image height in pixels
X0, 0, screen x of image top-left
Y0, 0, screen y of image top-left
SCALE_SHIFT, 0, upscale factor 2^SCALE_SHIFT (0..2)
MEM_LAT, 1, RAM read latency in cycles (address to q), 1..3
BASE_ADDR, 0, word address of pixel (0,0)
BORDER_RGB, 24'h000000, colour for active pixels outside the image

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
x  in  COORD_W  current screen column
y  in  COORD_W  current screen row
active  in  1  visible-area flag from timing generator
mode  in  1  0 = GRAY8, 1 = RGB332
mem_addr  out  ADDR_W  RAM word address (registered)
mem_rd_en  out  1  read strobe (registered)
mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after mem_addr/mem_rd_en
r  out  8  red
g  out  8  green
b  out  8  blue
pix_valid  out  1  r/g/b carry an in-image pixel
frame_done  out  1  one-cycle pulse on the last image pixel
frame_cnt  out  16  completed-frame counter, wraps at 0xFFFF

Behaviour:
- Reset (async, rst=1): mem_addr=0, mem_rd_en=0, r=g=b=0, pix_valid=0, frame_done=0, frame_cnt=0. Word hold register, last-issued-address valid flag and all pipeline valid bits are cleared. The pipeline is empty after release and no stale read data is used.
- Stage 0, inputs sampled every clk:
  - rx = x - X0 and ry = y - Y0 in signed COORD_W+1 arithmetic.
  - in_img = active && 0 <= rx < IMG_W<<SCALE_SHIFT && 0 <= ry < IMG_H<<SCALE_SHIFT.
  - sx = rx>>SCALE_SHIFT and sy = ry>>SCALE_SHIFT.
  - idx = sy*IMG_W + sx, computed at full width with no truncation.
  - waddr = BASE_ADDR + idx/PPW, truncated to ADDR_W.
  - lane = idx % PPW.
- Read suppression:
  - mem_rd_en is registered as in_img && (!last_ok || waddr != last_addr). mem_addr <= waddr whenever mem_rd_en is set; otherwise mem_addr holds its value.
  - last_addr/last_ok update on each issued read. last_ok clears on any cycle with in_img=0, so every line segment starts with a fresh read.
- Pipeline: in_img, active, lane, mode, issued flag and last-pixel flag are delayed MEM_LAT+1 stages to align with mem_rdata.
- Data stage:
  - If the aligned issued flag is set, the word is mem_rdata, and mem_rdata is captured into the hold register.
  - Otherwise the word is the hold register.
  - Reads return in order, so the hold register always contains the word addressed by the most recent issued read.
- Byte select: little-endian; lane 0 = word[7:0], lane k = word[8k+7:8k].
- Colour expansion, byte p:
  - GRAY8: r = g = b = p.
  - RGB332: r = {p[7:5],p[7:5],p[7:6]}, g = {p[4:2],p[4:2],p[4:3]}, b = {p[1:0],p[1:0],p[1:0],p[1:0]}.
- Output register, total latency L = MEM_LAT+2 cycles from x/y sample to r/g/b:
  - in_img: expanded pixel, pix_valid=1.
  - active && !in_img: BORDER_RGB, pix_valid=0.
  - !active: 0, pix_valid=0.
- frame_done pulses with the output of the pixel at rx = (IMG_W<<SCALE_SHIFT)-1, ry = (IMG_H<<SCALE_SHIFT)-1; frame_cnt increments in the same cycle. A repeated coordinate produces one pulse per occurrence.
- Mode is sampled per pixel at stage 0, so a mid-line change takes effect exactly L cycles later with no glitch on earlier pixels.
- Coordinates jumping backwards (new frame or line) need no special handling; address compare and in_img cover them.
- Reset mid-line drops all in-flight pixels. The first output after release is valid L cycles after the first sampled coordinate.

Test Plan:
1. Hold rst 3 cycles, release -> all outputs 0. Sample active=1, x=0, y=0 -> mem_rd_en=1 and mem_addr=0 next cycle.
2. MEM_LAT=1, RAM[0]=0x44332211, GRAY8, x=0..3 on consecutive cycles, y=0 -> exactly one read. r=g=b = 0x11, 0x22, 0x33, 0x44 at cycles 3..6. x=4 -> second read, mem_addr=1.
3. x=392, y=0, active=1, BORDER_RGB=24'h102030 -> r=0x10, g=0x20, b=0x30, pix_valid=0. active=0 -> rgb=0.
4. SCALE_SHIFT=1, RAM[0]=0x44332211, x=0..7 -> pixel pairs 11,11,22,22,33,33,44,44 from a single read.
5. mode=1, byte 0xE3 -> r=0xFF, g=0x00, b=0xFF. Toggle mode every pixel -> expansion alternates with L-cycle alignment.
6. Sweep full frame, X0=Y0=0 -> one frame_done on (391,391) output and frame_cnt=1. Assert rst mid-line at x=100 -> outputs 0 immediately, no spurious frame_done.
